// File: rtl/intr_pkg.sv
// intr_pkg: shared constants, state encoding and helpers for intr_ctrl4.
//   NSRC      number of interrupt sources
//   IDW       width of the granted source index
//   ST_IDLE   encoding of the idle state
//   ST_GRANT  encoding of the grant-outstanding state
//   id2mask   converts a source index into a one-hot source vector
package intr_pkg;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_e;

  function automatic logic [NSRC-1:0] id2mask(input logic [IDW-1:0] id);
    logic [NSRC-1:0] m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/p_encoder4to2.sv
// p_encoder4to2: combinational 4-to-2 priority encoder.
//   D  in  4  request vector; bit 3 has the highest priority
//   A  out 2  index of the highest set bit (00 when D is all zero)
module p_encoder4to2 (
  input  logic [3:0] D,
  output logic [1:0] A
);

  always_comb begin
    A = 2'd0;
    if (D[3])      A = 2'd3;
    else if (D[2]) A = 2'd2;
    else if (D[1]) A = 2'd1;
  end

endmodule

// File: rtl/intr_ctrl4.sv
// intr_ctrl4: four-source interrupt controller. Captures requests into a
// pending register, masks them, priority-encodes the eligible set and holds
// the winning index on a valid/ready handshake until it is accepted.
//   EDGE_MODE  1 = set on rising edge of req, 0 = set every cycle req is high
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        raw request lines (bit 3 highest priority)
//   mask       per-source enable, 1 = eligible
//   irq_valid  grant presented
//   irq_ready  consumer accepts grant
//   irq_id     granted source index
//   pending    pending register
//   overflow   one-cycle pulse: set event on an already pending bit
module intr_ctrl4
  import intr_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] mask,
  output logic            irq_valid,
  input  logic            irq_ready,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic            overflow
);

  state_e          r_state, w_state_nxt;
  logic [NSRC-1:0] r_req_q;
  logic [NSRC-1:0] r_pending;
  logic            r_irq_valid;
  logic [IDW-1:0]  r_irq_id;
  logic            r_overflow;

  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_eligible;
  logic [IDW-1:0]  w_enc_id;
  logic            w_hs;
  logic            w_load;

  assign w_set      = (EDGE_MODE != 0) ? (req & ~r_req_q) : req;
  assign w_hs       = r_irq_valid & irq_ready;
  assign w_clr      = w_hs ? id2mask(r_irq_id) : '0;
  assign w_eligible = r_pending & mask;

  p_encoder4to2 u_enc (
    .D (w_eligible),
    .A (w_enc_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_q     <= '0;
      r_pending   <= '0;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_q     <= req;
      // set is applied after clear so a same-cycle set wins
      r_pending   <= (r_pending & ~w_clr) | w_set;
      r_irq_valid <= (w_state_nxt == S_GRANT);
      if (w_load) r_irq_id <= w_enc_id;
      // a bit being cleared this cycle absorbs its new set without loss
      r_overflow  <= |(w_set & r_pending & ~w_clr);
    end
  end

  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_intr_ctrl4.sv
module tb_intr_ctrl4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, mask;
  logic       ready;

  logic       e_valid, l_valid, e_ovf, l_ovf;
  logic [1:0] e_id, l_id;
  logic [3:0] e_pend, l_pend;

  int n_chk = 0;
  int n_err = 0;

  // reference state, index 1 = edge-mode DUT, index 0 = level-mode DUT
  logic [3:0] m_pend[2];
  logic [3:0] m_reqq[2];
  logic       m_busy[2];
  logic [1:0] m_id[2];
  logic       m_ovf[2];

  always #5 clk = ~clk;

  intr_ctrl4 #(.EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .irq_valid(e_valid), .irq_ready(ready), .irq_id(e_id),
    .pending(e_pend), .overflow(e_ovf)
  );

  intr_ctrl4 #(.EDGE_MODE(0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .irq_valid(l_valid), .irq_ready(ready), .irq_id(l_id),
    .pending(l_pend), .overflow(l_ovf)
  );

  // Advance one edge: update the behavioural model with the inputs seen at
  // the edge, then let DUT outputs settle.
  task automatic tick();
    @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      if (rst) begin
        m_pend[md] = 0; m_reqq[md] = 0; m_busy[md] = 0; m_id[md] = 0; m_ovf[md] = 0;
      end else begin
        logic [3:0] pend_old;
        logic       hs;
        int         win;
        pend_old = m_pend[md];
        hs = m_busy[md] && ready;
        m_ovf[md] = 0;
        for (int i = 0; i < 4; i++) begin
          logic s, c;
          s = (md == 1) ? (req[i] && !m_reqq[md][i]) : req[i];
          c = hs && (m_id[md] == i);
          if (s && pend_old[i] && !c) m_ovf[md] = 1;
          m_pend[md][i] = s || (pend_old[i] && !c);
        end
        m_reqq[md] = req;
        if (m_busy[md]) begin
          if (hs) m_busy[md] = 0;
        end else begin
          win = -1;
          for (int i = 0; i < 4; i++) if (pend_old[i] && mask[i]) win = i;
          if (win >= 0) begin
            m_busy[md] = 1;
            m_id[md] = win[1:0];
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req = 0; mask = 4'hF; ready = 0;
    tick(); tick();
    n_chk++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b exp 0", e_valid); end
    n_chk++; if (e_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d exp 0", e_id); end
    n_chk++; if (e_pend !== 4'h0) begin n_err++; $display("FAIL reset_pend: got %b exp 0000", e_pend); end
    n_chk++; if (e_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b exp 0", e_ovf); end
    n_chk++; if (l_valid !== 1'b0) begin n_err++; $display("FAIL reset_lvalid: got %0b exp 0", l_valid); end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100; tick(); req = 0;
    n_chk++; if (e_pend !== 4'b0100) begin n_err++; $display("FAIL single_pend: got %b exp 0100", e_pend); end
    n_chk++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %0b exp 0", e_valid); end
    tick();
    n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd2) begin n_err++; $display("FAIL single_grant: got v=%0b id=%0d exp v=1 id=2", e_valid, e_id); end
    ready = 1; tick(); ready = 0;
    n_chk++; if (e_valid !== 1'b0 || e_pend !== 4'h0) begin n_err++; $display("FAIL single_ack: got v=%0b p=%b exp v=0 p=0000", e_valid, e_pend); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_ids[3];
    exp_ids[0] = 2'd3; exp_ids[1] = 2'd1; exp_ids[2] = 2'd0;
    req = 4'b1011; tick(); req = 0;
    n_chk++; if (e_pend !== 4'b1011) begin n_err++; $display("FAIL prio_pend: got %b exp 1011", e_pend); end
    ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (e_valid !== 1'b1 || e_id !== exp_ids[k]) begin n_err++; $display("FAIL prio_grant%0d: got v=%0b id=%0d exp v=1 id=%0d", k, e_valid, e_id, exp_ids[k]); end
      tick();
      n_chk++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL prio_idle%0d: got %0b exp 0", k, e_valid); end
    end
    n_chk++; if (e_pend !== 4'h0) begin n_err++; $display("FAIL prio_drain: got %b exp 0000", e_pend); end
    ready = 0;
  endtask

  task automatic test_mask();
    mask = 4'b0111; req = 4'b1010; tick(); req = 0; tick();
    n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd1) begin n_err++; $display("FAIL mask_first: got v=%0b id=%0d exp v=1 id=1", e_valid, e_id); end
    ready = 1; tick(); ready = 0;
    n_chk++; if (e_valid !== 1'b0 || e_pend !== 4'b1000) begin n_err++; $display("FAIL mask_hold: got v=%0b p=%b exp v=0 p=1000", e_valid, e_pend); end
    tick();
    n_chk++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL mask_blocked: got %0b exp 0", e_valid); end
    mask = 4'hF; tick();
    n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd3) begin n_err++; $display("FAIL mask_unmask: got v=%0b id=%0d exp v=1 id=3", e_valid, e_id); end
    ready = 1; tick(); ready = 0;
    n_chk++; if (e_pend !== 4'h0) begin n_err++; $display("FAIL mask_drain: got %b exp 0000", e_pend); end
  endtask

  task automatic test_overflow_stall();
    req = 4'b0001; tick(); req = 0; tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd0) begin n_err++; $display("FAIL stall%0d: got v=%0b id=%0d exp v=1 id=0", k, e_valid, e_id); end
    end
    n_chk++; if (e_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_quiet: got %0b exp 0", e_ovf); end
    req = 4'b0001; tick(); req = 0;
    n_chk++; if (e_ovf !== 1'b1 || e_id !== 2'd0) begin n_err++; $display("FAIL ovf_pulse: got o=%0b id=%0d exp o=1 id=0", e_ovf, e_id); end
    req = 4'b1000; tick(); req = 0;
    n_chk++; if (e_ovf !== 1'b0 || e_id !== 2'd0 || e_valid !== 1'b1) begin n_err++; $display("FAIL ovf_once: got o=%0b v=%0b id=%0d exp o=0 v=1 id=0", e_ovf, e_valid, e_id); end
    ready = 1; tick(); ready = 0;
    n_chk++; if (e_valid !== 1'b0 || e_pend !== 4'b1000) begin n_err++; $display("FAIL stall_ack: got v=%0b p=%b exp v=0 p=1000", e_valid, e_pend); end
    tick();
    n_chk++; if (e_id !== 2'd3) begin n_err++; $display("FAIL stall_next: got %0d exp 3", e_id); end
    ready = 1; tick(); ready = 0; tick();
  endtask

  task automatic test_level();
    req = 4'b0100; ready = 1; tick(); tick();
    n_chk++; if (l_valid !== 1'b1 || l_id !== 2'd2) begin n_err++; $display("FAIL lvl_first: got v=%0b id=%0d exp v=1 id=2", l_valid, l_id); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (l_valid !== 1'b0 || l_pend !== 4'b0100) begin n_err++; $display("FAIL lvl_idle%0d: got v=%0b p=%b exp v=0 p=0100", k, l_valid, l_pend); end
      tick();
      n_chk++; if (l_valid !== 1'b1 || l_id !== 2'd2) begin n_err++; $display("FAIL lvl_regrant%0d: got v=%0b id=%0d exp v=1 id=2", k, l_valid, l_id); end
    end
    req = 0; tick();
    n_chk++; if (l_valid !== 1'b0 || l_pend !== 4'h0) begin n_err++; $display("FAIL lvl_drop: got v=%0b p=%b exp v=0 p=0000", l_valid, l_pend); end
    tick(); tick();
    n_chk++; if (l_valid !== 1'b0) begin n_err++; $display("FAIL lvl_quiet: got %0b exp 0", l_valid); end
    ready = 0;
  endtask

  task automatic test_reset_mid();
    req = 4'b0010; ready = 0; tick(); tick();
    n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd1) begin n_err++; $display("FAIL rmid_grant: got v=%0b id=%0d exp v=1 id=1", e_valid, e_id); end
    rst = 1; ready = 1; tick(); rst = 0; ready = 0;
    n_chk++; if ({e_valid, e_id, e_pend, e_ovf} !== 8'h00) begin n_err++; $display("FAIL rmid_clear: got v=%0b id=%0d p=%b o=%0b exp all 0", e_valid, e_id, e_pend, e_ovf); end
    tick();
    n_chk++; if (e_pend !== 4'b0010 || e_valid !== 1'b0) begin n_err++; $display("FAIL rmid_reset_edge: got v=%0b p=%b exp v=0 p=0010", e_valid, e_pend); end
    tick();
    n_chk++; if (e_valid !== 1'b1 || e_id !== 2'd1) begin n_err++; $display("FAIL rmid_regrant: got v=%0b id=%0d exp v=1 id=1", e_valid, e_id); end
    req = 0; ready = 1; tick(); ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom_range(0, 15));
      mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 60) == 0);
      tick();
      n_chk++; if (e_valid !== m_busy[1] || (m_busy[1] && e_id !== m_id[1])) begin n_err++; $display("FAIL rnd_e_grant c=%0d: got v=%0b id=%0d exp v=%0b id=%0d", c, e_valid, e_id, m_busy[1], m_id[1]); end
      n_chk++; if (e_pend !== m_pend[1] || e_ovf !== m_ovf[1]) begin n_err++; $display("FAIL rnd_e_pend c=%0d: got p=%b o=%0b exp p=%b o=%0b", c, e_pend, e_ovf, m_pend[1], m_ovf[1]); end
      n_chk++; if (l_valid !== m_busy[0] || (m_busy[0] && l_id !== m_id[0])) begin n_err++; $display("FAIL rnd_l_grant c=%0d: got v=%0b id=%0d exp v=%0b id=%0d", c, l_valid, l_id, m_busy[0], m_id[0]); end
      n_chk++; if (l_pend !== m_pend[0] || l_ovf !== m_ovf[0]) begin n_err++; $display("FAIL rnd_l_pend c=%0d: got p=%b o=%0b exp p=%b o=%0b", c, l_pend, l_ovf, m_pend[0], m_ovf[0]); end
    end
    rst = 0; req = 0; mask = 4'hF; ready = 0;
  endtask

  initial begin
    for (int md = 0; md < 2; md++) begin
      m_pend[md] = 0; m_reqq[md] = 0; m_busy[md] = 0; m_id[md] = 0; m_ovf[md] = 0;
    end
    rst = 1; req = 0; mask = 4'hF; ready = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overflow_stall();
    test_level();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
